// File: rtl/jtopl_pkg.sv
// jtopl_pkg: shared LFO widths and default frame divisors for the LFO, EG final stage and PG
package jtopl_pkg;

    localparam int LFO_AM_W   = 7;
    localparam int LFO_PM_W   = 3;
    localparam int LFO_AM_DIV = 64;
    localparam int LFO_PM_DIV = 1024;

    // Triangle magnitude seen by the consumer: bit 6 selects the falling half, which is inverted
    function automatic logic [LFO_AM_W-2:0] lfo_am_level(input logic [LFO_AM_W-1:0] m);
        return m[LFO_AM_W-1] ? ~m[LFO_AM_W-2:0] : m[LFO_AM_W-2:0];
    endfunction

endpackage

// File: rtl/jtopl_lfo_am_if.sv
// jtopl_lfo_am_if: frame timing and control inputs plus modulation outputs of the LFO
interface jtopl_lfo_am_if;
    import jtopl_pkg::*;

    logic                cenop;
    logic                zero;
    logic                lfo_rst;
    logic                test_fast;
    logic [LFO_AM_W-1:0] lfo_mod;
    logic [LFO_PM_W-1:0] vib_cnt;
    logic                am_wrap;

    modport master (
        output cenop, zero, lfo_rst, test_fast,
        input  lfo_mod, vib_cnt, am_wrap
    );

    modport slave (
        input  cenop, zero, lfo_rst, test_fast,
        output lfo_mod, vib_cnt, am_wrap
    );

endinterface

// File: rtl/jtopl_lfo_div.sv
// jtopl_lfo_div: frame prescaler, emits a step on the frame tick that hits DIV-1 (or any tick when forced)
module jtopl_lfo_div #(
    parameter int DIV = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic clr_i,
    input  logic fast_i,
    output logic step_o
);
    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] TERM = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         term;

    assign term   = cnt_q == TERM;
    assign step_o = tick_i & (fast_i | term);

    // Count frame ticks; the forced step in test mode leaves the count untouched
    always_comb cnt_d = clr_i ? '0 : !tick_i ? cnt_q : term ? '0 : cnt_q + W'(1);

    // Prescaler register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/jtopl_lfo_am.sv
// jtopl_lfo_am: frame-rate LFO producing the tremolo phase word and vibrato phase
module jtopl_lfo_am
    import jtopl_pkg::*;
#(
    parameter int AM_DIV = LFO_AM_DIV,
    parameter int PM_DIV = LFO_PM_DIV
) (
    input  logic                clk,
    input  logic                rst_n,
    jtopl_lfo_am_if.slave       bus
);
    logic                frame_tick, am_step, pm_step;
    logic [LFO_AM_W-1:0] lfo_mod_q, lfo_mod_d;
    logic [LFO_PM_W-1:0] vib_q, vib_d;
    logic                wrap_q, wrap_d;

    assign frame_tick = bus.cenop & bus.zero;

    jtopl_lfo_div #(.DIV(AM_DIV)) u_am_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_i (frame_tick),
        .clr_i  (bus.lfo_rst),
        .fast_i (bus.test_fast),
        .step_o (am_step)
    );

    jtopl_lfo_div #(.DIV(PM_DIV)) u_pm_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_i (frame_tick),
        .clr_i  (bus.lfo_rst),
        .fast_i (bus.test_fast),
        .step_o (pm_step)
    );

    // Phase advance; the LFO clear wins over a coincident step
    always_comb begin
        lfo_mod_d = bus.lfo_rst ? '0 : lfo_mod_q + LFO_AM_W'(am_step);
        vib_d     = bus.lfo_rst ? '0 : vib_q + LFO_PM_W'(pm_step);
        wrap_d    = ~bus.lfo_rst & am_step & (&lfo_mod_q);
    end

    // Phase and wrap registers, updated only on frame boundaries or clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            lfo_mod_q <= '0;
            vib_q     <= '0;
            wrap_q    <= 1'b0;
        end else begin
            lfo_mod_q <= lfo_mod_d;
            vib_q     <= vib_d;
            wrap_q    <= wrap_d;
        end

    assign bus.lfo_mod = lfo_mod_q;
    assign bus.vib_cnt = vib_q;
    assign bus.am_wrap = wrap_q;

endmodule

// File: tb/tb_jtopl_lfo_am.sv
// tb_jtopl_lfo_am: directed stimulus with a step-count model compared every cycle
module tb_jtopl_lfo_am;
    localparam int AM_DIV = 64;
    localparam int PM_DIV = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   wrap_cnt = 0;

    jtopl_lfo_am_if bus();

    jtopl_lfo_am #(.AM_DIV(AM_DIV), .PM_DIV(PM_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: count frame ticks since the last clear and the steps they imply
    int am_t, pm_t, am_n, pm_n;
    bit wrap_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.lfo_rst) begin
            am_t <= 0; pm_t <= 0; am_n <= 0; pm_n <= 0; wrap_m <= 0;
        end else begin
            wrap_m <= 0;
            if (bus.cenop && bus.zero) begin
                am_t <= am_t + 1;
                pm_t <= pm_t + 1;
                if (bus.test_fast || (am_t + 1) % AM_DIV == 0) begin
                    am_n   <= am_n + 1;
                    wrap_m <= (am_n + 1) % 128 == 0;
                end
                if (bus.test_fast || (pm_t + 1) % PM_DIV == 0) pm_n <= pm_n + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("model lfo_mod", int'(bus.lfo_mod), am_n % 128);
        check("model vib_cnt", int'(bus.vib_cnt), pm_n % 8);
        check("model am_wrap", int'(bus.am_wrap), int'(wrap_m));
        if (bus.am_wrap) wrap_cnt++;
    end

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.cenop = 1; bus.zero = 0;
            @(negedge clk);
            bus.zero = 1;
            @(negedge clk);
            bus.zero = 0;
        end
    endtask

    task automatic outs(input string tag, input int lm, input int vc, input int aw);
        check({tag, " lfo_mod"}, int'(bus.lfo_mod), lm);
        check({tag, " vib_cnt"}, int'(bus.vib_cnt), vc);
        check({tag, " am_wrap"}, int'(bus.am_wrap), aw);
    endtask

    initial begin
        bus.cenop = 0; bus.zero = 0; bus.lfo_rst = 0; bus.test_fast = 0;
        repeat (3) @(negedge clk);
        outs("reset", 0, 0, 0);
        rst_n = 1;
        ticks(63);
        outs("tick63", 0, 0, 0);
        ticks(1);
        outs("tick64", 1, 0, 0);
        ticks(960);
        outs("tick1024", 16, 1, 0);
        ticks(7104);
        outs("tick8128", 127, 7, 0);
        ticks(63);
        wrap_cnt = 0;
        ticks(1);
        outs("tick8192", 0, 0, 1);
        @(negedge clk);
        check("wrap after", int'(bus.am_wrap), 0);
        check("wrap pulses", wrap_cnt, 1);

        bus.lfo_rst = 1;
        @(negedge clk);
        bus.lfo_rst = 0;
        outs("lfo_rst", 0, 0, 0);
        bus.test_fast = 1;
        ticks(10);
        bus.test_fast = 0;
        outs("fast10", 10, 2, 0);

        bus.cenop = 1; bus.zero = 0;
        repeat (1000) @(negedge clk);
        bus.cenop = 0; bus.zero = 1;
        repeat (20) @(negedge clk);
        bus.zero = 0;
        outs("no tick", 10, 2, 0);
        ticks(53);
        outs("pre kept 63", 10, 2, 0);
        ticks(1);
        outs("pre kept 64", 11, 2, 0);

        bus.lfo_rst = 1;
        @(negedge clk);
        bus.lfo_rst = 0;
        bus.test_fast = 1;
        ticks(45);
        bus.test_fast = 0;
        ticks(18);
        outs("at 45", 45, 5, 0);
        bus.cenop = 1; bus.zero = 0;
        @(negedge clk);
        bus.zero = 1; bus.lfo_rst = 1;
        @(negedge clk);
        bus.zero = 0; bus.lfo_rst = 0;
        outs("rst vs step", 0, 0, 0);
        ticks(63);
        outs("post clr 63", 0, 0, 0);
        ticks(1);
        outs("post clr 64", 1, 0, 0);

        bus.lfo_rst = 1; bus.test_fast = 1;
        ticks(5);
        outs("rst held", 0, 0, 0);
        bus.lfo_rst = 0;
        ticks(100);
        bus.test_fast = 0;
        outs("at 100", 100, 4, 0);
        bus.cenop = 1; bus.zero = 0;
        @(posedge clk);
        #2 rst_n = 0;
        #1 outs("async rst", 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        ticks(63);
        outs("rel 63", 0, 0, 0);
        ticks(1);
        outs("rel 64", 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
